// File: rtl/ecc_pkg.sv
// ============================================================================
// Module   : ecc_pkg
// Purpose  : Shared defaults and serializer state encoding for kp_serializer.
//            KP_SER_CHECKSUM_EN adds the CHK state.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ecc_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int NIB_W_DEF = 4;
   localparam int NIBS      = WIDTH_DEF / NIB_W_DEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_X = 2'd1,
      SEND_Y = 2'd2
`ifdef KP_SER_CHECKSUM_EN
      ,
      CHK    = 2'd3
`endif
   } kp_state_e;

   // A single-beat coordinate still needs a one-bit counter to stay legal.
   function automatic int cnt_width(input int nibs);
      return (nibs > 1) ? $clog2(nibs) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nib_shreg.sv
// ============================================================================
// Module   : nib_shreg
// Purpose  : Loadable WIDTH-bit register shifting right by NIB_W with hold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nib_shreg #(
   parameter int WIDTH = 32,
   parameter int NIB_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_shift,
   output logic [NIB_W-1:0] o_nib
);

   logic [WIDTH-1:0] r_q;

   // Load wins over shift so a new frame can start on the last-beat transfer.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else if (i_shift) begin
         r_q <= r_q >> NIB_W;
      end
   end

   assign o_nib = r_q[NIB_W-1:0];

endmodule

`default_nettype wire

// File: rtl/kp_serializer.sv
// ============================================================================
// Module   : kp_serializer
// Purpose  : Streams a kP result (x then y) as NIB_W-bit beats, LSB first,
//            with valid/ready handshake. KP_SER_CHECKSUM_EN appends XOR beat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kp_serializer
   import ecc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NIB_W = NIB_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_done,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic             i_ready,
   output logic [NIB_W-1:0] o_kp,
   output logic             o_valid,
   output logic             o_last,
   output logic             o_busy,
   output logic             o_drop
);

   localparam int c_nibs  = WIDTH / NIB_W;
   localparam int c_cnt_w = cnt_width(c_nibs);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nibs - 1);

   kp_state_e          r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_valid;
   logic               r_last;
   logic               r_busy;
   logic               r_drop;
   logic [NIB_W-1:0]   w_x_nib;
   logic [NIB_W-1:0]   w_y_nib;
   logic [NIB_W-1:0]   w_kp;
   logic               w_xfer;
   logic               w_last_xfer;
   logic               w_capture;
   logic               w_shift_x;
   logic               w_shift_y;
`ifdef KP_SER_CHECKSUM_EN
   logic [NIB_W-1:0]   r_chk;
`endif

   assign w_xfer      = r_valid && i_ready;
   assign w_last_xfer = w_xfer && r_last;
   assign w_capture   = i_done && ((r_state == IDLE) || w_last_xfer);
   assign w_shift_x   = w_xfer && (r_state == SEND_X);
   assign w_shift_y   = w_xfer && (r_state == SEND_Y);

   nib_shreg #(
      .WIDTH (WIDTH),
      .NIB_W (NIB_W)
   ) u_x_shreg (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_capture),
      .i_d     (i_x),
      .i_shift (w_shift_x),
      .o_nib   (w_x_nib)
   );

   nib_shreg #(
      .WIDTH (WIDTH),
      .NIB_W (NIB_W)
   ) u_y_shreg (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_capture),
      .i_d     (i_y),
      .i_shift (w_shift_y),
      .o_nib   (w_y_nib)
   );

   // The current beat is always the low nibble of the active shift register.
   always_comb begin
      w_kp = '0;
      case (r_state)
         SEND_X:  w_kp = w_x_nib;
         SEND_Y:  w_kp = w_y_nib;
`ifdef KP_SER_CHECKSUM_EN
         CHK:     w_kp = r_chk;
`endif
         default: w_kp = '0;
      endcase
   end

   assign o_kp    = w_kp;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_busy  = r_busy;
   assign o_drop  = r_drop;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_drop  <= 1'b0;
`ifdef KP_SER_CHECKSUM_EN
         r_chk   <= '0;
`endif
      end else begin
         r_drop <= i_done && r_busy && !w_last_xfer;
         if (w_capture) begin
            r_state <= SEND_X;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef KP_SER_CHECKSUM_EN
            r_chk   <= '0;
`endif
         end else if (w_xfer) begin
            case (r_state)
               SEND_X: begin
`ifdef KP_SER_CHECKSUM_EN
                  r_chk <= r_chk ^ w_kp;
`endif
                  if (r_cnt == c_last) begin
                     r_state <= SEND_Y;
                     r_cnt   <= '0;
`ifdef KP_SER_CHECKSUM_EN
                     r_last  <= 1'b0;
`else
                     r_last  <= (c_nibs == 1);
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               SEND_Y: begin
`ifdef KP_SER_CHECKSUM_EN
                  r_chk <= r_chk ^ w_kp;
`endif
                  if (r_cnt == c_last) begin
                     r_cnt   <= '0;
`ifdef KP_SER_CHECKSUM_EN
                     r_state <= CHK;
                     r_last  <= 1'b1;
`else
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
`ifdef KP_SER_CHECKSUM_EN
                     r_last <= 1'b0;
`else
                     r_last <= ((r_cnt + 1'b1) == c_last);
`endif
                  end
               end
               default: begin
                  // Checksum beat accepted (or stray state): frame is over.
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_kp_serializer.sv
// ============================================================================
// Module   : tb_kp_serializer
// Purpose  : Directed self-checking bench for kp_serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_kp_serializer;

   localparam int WIDTH = 32;
   localparam int NIB_W = 4;
`ifdef KP_SER_CHECKSUM_EN
   localparam int NB = 17;
`else
   localparam int NB = 16;
`endif
   localparam logic [31:0] X0 = 32'h87654321;
   localparam logic [31:0] Y0 = 32'h0FEDCBA9;
   localparam logic [31:0] X1 = 32'h1234567A;
   localparam logic [31:0] Y1 = 32'hDEADBEEF;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b0;
   logic             i_done = 1'b0;
   logic             i_ready = 1'b0;
   logic [WIDTH-1:0] i_x = '0;
   logic [WIDTH-1:0] i_y = '0;
   logic [NIB_W-1:0] o_kp;
   logic             o_valid;
   logic             o_last;
   logic             o_busy;
   logic             o_drop;

   int n_chk = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   kp_serializer #(
      .WIDTH (WIDTH),
      .NIB_W (NIB_W)
   ) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_done  (i_done),
      .i_x     (i_x),
      .i_y     (i_y),
      .i_ready (i_ready),
      .o_kp    (o_kp),
      .o_valid (o_valid),
      .o_last  (o_last),
      .o_busy  (o_busy),
      .o_drop  (o_drop)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   // Beat b of a frame: x nibbles, y nibbles, then the XOR of all of them.
   function automatic logic [3:0] exp_nib(input logic [31:0] x, input logic [31:0] y, input int b);
      logic [3:0] acc;
      acc = '0;
      if (b < 8) return x[4*b +: 4];
      if (b < 16) return y[4*(b-8) +: 4];
      for (int i = 0; i < 8; i++) acc = acc ^ x[4*i +: 4] ^ y[4*i +: 4];
      return acc;
   endfunction

   task automatic start(input logic [31:0] x, input logic [31:0] y);
      i_x    = x;
      i_y    = y;
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
   endtask

   // Walks a frame whose first beat is already on the outputs.
   task automatic stream(input logic [31:0] x, input logic [31:0] y, input int stall_b,
                         input int drop_b, input bit b2b, input logic [31:0] nx,
                         input logic [31:0] ny);
      for (int b = 0; b < NB; b++) begin
         if (b == stall_b) begin
            i_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick;
               check($sformatf("stall%0d_kp", s), o_kp, exp_nib(x, y, b));
               check($sformatf("stall%0d_valid", s), o_valid, 1);
            end
            i_ready = 1'b1;
         end
         check($sformatf("beat%0d_kp", b + 1), o_kp, exp_nib(x, y, b));
         check($sformatf("beat%0d_valid", b + 1), o_valid, 1);
         check($sformatf("beat%0d_last", b + 1), o_last, (b == NB - 1));
         check($sformatf("beat%0d_busy", b + 1), o_busy, 1);
         check($sformatf("beat%0d_drop", b + 1), o_drop, (drop_b >= 0 && b == drop_b + 1));
         if (b == drop_b || (b2b && b == NB - 1)) begin
            i_x    = b2b ? nx : 32'hFFFFFFFF;
            i_y    = b2b ? ny : 32'hFFFFFFFF;
            i_done = 1'b1;
            tick;
            i_done = 1'b0;
         end else begin
            tick;
         end
      end
      if (b2b) begin
         check("b2b_valid", o_valid, 1);
         check("b2b_kp", o_kp, nx[3:0]);
         check("b2b_busy", o_busy, 1);
         check("b2b_drop", o_drop, 0);
      end else begin
         check("end_valid", o_valid, 0);
         check("end_busy", o_busy, 0);
         check("end_last", o_last, 0);
      end
   endtask

   initial begin
      i_ready = 1'b1;
      repeat (2) tick;
      check("rst_kp", o_kp, 0);
      check("rst_valid", o_valid, 0);
      check("rst_last", o_last, 0);
      check("rst_busy", o_busy, 0);
      check("rst_drop", o_drop, 0);
      i_rst = 1'b1;
      repeat (2) tick;
      check("idle_ready_valid", o_valid, 0);

      start(X0, Y0);
      stream(X0, Y0, -1, -1, 1'b0, '0, '0);
      tick;

      start(X0, Y0);
      stream(X0, Y0, 4, -1, 1'b0, '0, '0);

      start(X0, Y0);
      stream(X0, Y0, -1, 3, 1'b0, '0, '0);
      check("post_drop_pulse", o_drop, 0);

      start(X0, Y0);
      stream(X0, Y0, -1, -1, 1'b1, X1, Y1);
      stream(X1, Y1, -1, -1, 1'b0, '0, '0);

      // Abort on beat 9, then a clean frame after release.
      start(X0, Y0);
      repeat (8) tick;
      check("pre_abort_kp", o_kp, 4'h9);
      i_rst = 1'b0;
      #1;
      check("abort_kp", o_kp, 0);
      check("abort_valid", o_valid, 0);
      check("abort_last", o_last, 0);
      check("abort_busy", o_busy, 0);
      check("abort_drop", o_drop, 0);
      repeat (2) tick;
      i_rst = 1'b1;
      repeat (2) tick;
      check("release_valid", o_valid, 0);
      check("release_busy", o_busy, 0);
      start(X1, Y1);
      stream(X1, Y1, -1, -1, 1'b0, '0, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
